digitube_scanner: RTL and testbench

Parametrised scanning driver for multiplexed 7‑segment displays. It holds NUM_DIGITS hex digits, each with its own decimal point and enable, in a double buffer. It then time‑multiplexes them onto one shared active‑low segment bus, driving a one‑hot active‑high anode select. A programmable blanking gap at the start of each digit slot suppresses ghosting. New display contents are taken through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits.

---
 rtl/digitube_pkg.sv | 26 ++
 rtl/digitube_scanner_if.sv | 23 ++
 rtl/seg7_decode.sv | 12 +
 rtl/digitube_scanner.sv | 131 +++++++++++++
 tb/tb_digitube_scanner.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/digitube_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: the blank pattern,
// the active-low hex font and the layout of one digit field in the update word.
package digitube_pkg;

    // Every segment off (active-low bus)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // One digit field is {en, dp, hex[3:0]}
    localparam int DIGIT_W       = 6;
    localparam int DIGIT_EN      = 5;
    localparam int DIGIT_DP      = 4;
    localparam int DIGIT_HEX_MSB = 3;
    localparam int DIGIT_HEX_LSB = 0;

    // Active-low font {g,f,e,d,c,b,a}, entry 15 on the left down to entry 0 on the right
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Look up the segment pattern for one hex nibble
    function automatic logic [6:0] fontLookup(input logic [3:0] hex);
        return HEX_FONT[hex];
    endfunction

endpackage

// File: rtl/digitube_scanner_if.sv
// Update handshake and display bus of the scanner. The slave side is the
// scanner itself; the master side offers new contents and watches the display.
interface digitube_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    upd_valid;
    logic                    upd_ready;
    logic [6*NUM_DIGITS-1:0] upd_data;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_start;

    modport master (
        output upd_valid, upd_data,
        input  upd_ready, an, seg, dp, frame_start
    );

    modport slave (
        input  upd_valid, upd_data,
        output upd_ready, an, seg, dp, frame_start
    );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder driving the shared active-low bus.
module seg7_decode
    import digitube_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Font lookup for the currently selected digit
    always_comb seg_o = fontLookup(hex_i);

endmodule

// File: rtl/digitube_scanner.sv
// Scanning driver for a multiplexed 7-segment display. A slot counter and a
// digit index walk through the digits; new contents are staged through a
// valid/ready handshake and swapped in only at the frame boundary, so a frame
// never mixes old and new digits. All display outputs are registered and
// lag the counters by one cycle.
module digitube_scanner
    import digitube_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                reset,
    digitube_scanner_if.slave   bus
);

    localparam int CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DATA_W = DIGIT_W * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     staging_q, staging_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frameStart_q, frameStart_d;

    logic                  cntWrap;
    logic                  frameBoundary;
    logic                  transfer;
    logic                  blankPhase;
    logic [DIGIT_W-1:0]    curDigit;
    logic [NUM_DIGITS-1:0] anOneHot;
    logic [6:0]            decodedSeg;

    // Select the digit being scanned and build its one-hot anode pattern
    always_comb begin
        curDigit = '0;
        anOneHot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                curDigit    = active_q[DIGIT_W*i +: DIGIT_W];
                anOneHot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .hex_i (curDigit[DIGIT_HEX_MSB:DIGIT_HEX_LSB]),
        .seg_o (decodedSeg)
    );

    // The blank gap is decoded from the slot counter rather than held as state
    assign blankPhase    = (32'(cnt_q) < 32'(BLANK_CYCLES));
    assign cntWrap       = (cnt_q == CNT_LAST);
    assign frameBoundary = cntWrap && (idx_q == IDX_LAST);
    assign transfer      = bus.upd_valid && !pending_q;

    // Next state of counters, double buffer and registered display outputs
    always_comb begin
        cnt_d     = cntWrap ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        staging_d = staging_q;
        active_d  = active_q;
        pending_d = pending_q;

        if (cntWrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        if (frameBoundary && pending_q) begin
            active_d  = staging_q;
            pending_d = 1'b0;
        end

        if (transfer) begin
            staging_d = bus.upd_data;
            pending_d = 1'b1;
        end

        frameStart_d = (cnt_q == '0) && (idx_q == '0);

        if (!blankPhase && curDigit[DIGIT_EN]) begin
            an_d  = anOneHot;
            seg_d = decodedSeg;
            dp_d  = ~curDigit[DIGIT_DP];
        end else begin
            an_d  = '0;
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    // State and output registers; reset discards staged data and blanks the display
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            staging_q    <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frameStart_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign bus.upd_ready   = ~pending_q;
    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frameStart_q;

endmodule

// File: tb/tb_digitube_scanner.sv
// Directed bench for the 7-segment scanner with 4 digits, 8-cycle slots and a
// 2-cycle blank gap. Expected display cycles are queued as stimulus is driven
// and compared one per clock as the scanner produces them.
module tb_digitube_scanner;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * SLOT;

    localparam logic [23:0] D1   = {6'h24, 6'h23, 6'h22, 6'h21};
    localparam logic [23:0] D2   = {6'h29, 6'h27, 6'h36, 6'h25};
    localparam logic [23:0] DBAD = {6'h2E, 6'h2E, 6'h2E, 6'h2E};
    localparam logic [23:0] D3   = {6'h2D, 6'h2C, 6'h2B, 6'h2A};
    localparam logic [23:0] D4   = {6'h3F, 6'h15, 6'h2A, 6'h38};
    localparam logic [23:0] D5   = {6'h21, 6'h21, 6'h21, 6'h21};

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cycleNo;
    obs_t sbQueue[$];

    digitube_scanner_if #(.NUM_DIGITS(ND)) bus ();

    digitube_scanner #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] fontRef(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected display for output cycle t (0..FRAME-1) of a frame showing contents c
    function automatic obs_t expectAt(input logic [23:0] c, input int t);
        obs_t       e;
        int         slot;
        int         inSlot;
        logic [5:0] d;
        slot   = t / SLOT;
        inSlot = t % SLOT;
        d      = c[6*slot +: 6];
        e.fs   = (t == 0);
        if (inSlot < BLANK || !d[5]) begin
            e.an  = 4'b0000;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = 4'(1 << slot);
            e.seg = fontRef(d[3:0]);
            e.dp  = ~d[4];
        end
        return e;
    endfunction

    task automatic pushFrame(input logic [23:0] c);
        for (int t = 0; t < FRAME; t++) sbQueue.push_back(expectAt(c, t));
    endtask

    task automatic pushBlank(input logic fs);
        obs_t e;
        e.an  = 4'b0000;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fs  = fs;
        sbQueue.push_back(e);
    endtask

    task automatic applyStimulus(input logic valid, input logic [23:0] data);
        bus.upd_valid = valid;
        bus.upd_data  = data;
    endtask

    // Compare the display against the oldest queued expectation
    task automatic checkOutput();
        obs_t obs;
        obs_t exp;
        obs = {bus.an, bus.seg, bus.dp, bus.frame_start};
        checks++;
        if (sbQueue.size() == 0) begin
            failures++;
            $display("[TB] FAIL underflow cycle%0d observed=%h required=queued expectation", cycleNo, obs);
        end else begin
            exp = sbQueue.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("[TB] FAIL display cycle%0d observed an=%b seg=%h dp=%b fs=%b expected an=%b seg=%h dp=%b fs=%b",
                       cycleNo, obs.an, obs.seg, obs.dp, obs.fs, exp.an, exp.seg, exp.dp, exp.fs);
            end
        end
    endtask

    task automatic checkReady(input logic expected, input string tag);
        checks++;
        assert (bus.upd_ready === expected) else begin
            failures++;
            $error("[TB] FAIL %s cycle%0d observed upd_ready=%b expected=%b", tag, cycleNo, bus.upd_ready, expected);
        end
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cycleNo++;
            checkOutput();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycleNo  = 0;
        reset    = 1'b1;
        applyStimulus(1'b0, '0);

        // Reset held for three edges
        for (int i = 0; i < 3; i++) pushBlank(1'b0);
        stepCycles(3);
        checkReady(1'b1, "ready_after_reset");
        reset = 1'b0;

        // Two idle frames: blank display, frame_start every 32 cycles
        pushFrame('0);
        pushFrame('0);
        stepCycles(2 * FRAME);
        checkReady(1'b1, "ready_idle");

        // Mid-frame transfer of D1, visible from the next frame
        pushFrame('0);
        stepCycles(10);
        applyStimulus(1'b1, D1);
        checkReady(1'b1, "ready_before_d1");
        stepCycles(1);
        applyStimulus(1'b0, DBAD);
        pushFrame(D1);
        checkReady(1'b0, "ready_pending_d1");
        stepCycles(FRAME - 11);
        checkReady(1'b1, "ready_after_d1_applied");

        // D2 accepted, then an offer while pending is ignored
        stepCycles(4);
        applyStimulus(1'b1, D2);
        stepCycles(1);
        pushFrame(D2);
        applyStimulus(1'b0, '0);
        checkReady(1'b0, "ready_pending_d2");
        stepCycles(4);
        applyStimulus(1'b1, DBAD);
        stepCycles(3);
        checkReady(1'b0, "ready_ignores_offer");
        applyStimulus(1'b0, '0);
        stepCycles(FRAME - 12);
        checkReady(1'b1, "ready_after_d2_applied");

        // D3 transferred on the boundary edge: shown one full frame later
        stepCycles(FRAME - 1);
        applyStimulus(1'b1, D3);
        stepCycles(1);
        applyStimulus(1'b0, '0);
        checkReady(1'b0, "ready_boundary_capture");
        pushFrame(D2);
        pushFrame(D3);
        stepCycles(FRAME);
        checkReady(1'b1, "ready_after_d3_applied");

        // D4: hex 8 with dp, disabled digit 2, hex F with dp
        stepCycles(5);
        applyStimulus(1'b1, D4);
        stepCycles(1);
        applyStimulus(1'b0, '0);
        pushFrame(D4);
        stepCycles(FRAME - 6);
        stepCycles(FRAME);

        // D5 pending, then reset at idx=2 cnt=5 discards it
        pushFrame(D4);
        stepCycles(3);
        applyStimulus(1'b1, D5);
        stepCycles(1);
        applyStimulus(1'b0, '0);
        checkReady(1'b0, "ready_pending_d5");
        stepCycles(17);
        sbQueue.delete();
        reset = 1'b1;
        pushBlank(1'b0);
        stepCycles(1);
        checkReady(1'b1, "ready_mid_frame_reset");
        reset = 1'b0;
        pushFrame('0);
        pushFrame('0);
        stepCycles(2 * FRAME);
        checkReady(1'b1, "ready_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
